// File: rtl/upload_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upload_arb_pkg
// Description : FSM encoding and framing constants shared by upload_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package upload_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_CHID = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } arb_state_t;

    localparam logic [7:0] c_sync_byte_default = 8'hAA;

    // Channel-ID byte: upper nibble reserved as zero, channel index below.
    function automatic logic [7:0] chid_byte(input logic [3:0] idx);
        return {4'h0, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin requester select with one-hot grant and a pointer
//               that moves to the granted channel on an advance strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;
    logic             w_hi_found;
    logic             w_lo_found;
    logic             w_any;

    // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(r_ptr)) begin
                    w_hi_idx   = IDX_W'(i);
                    w_hi_found = 1'b1;
                end else begin
                    w_lo_idx   = IDX_W'(i);
                    w_lo_found = 1'b1;
                end
            end
        end
    end

    assign w_any     = w_hi_found | w_lo_found;
    assign grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = w_any && (grant_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= IDX_W'(NUM_CH - 1);
        end else if (advance && w_any) begin
            r_ptr <= grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/upload_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : upload_arbiter
// Description : Multiplexes per-channel byte streams into framed USB uploads:
//               SYNC, channel ID, payload (max MAX_LEN), XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module upload_arbiter
    import upload_arb_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         MAX_LEN   = 64,
    parameter logic [7:0] SYNC_BYTE = c_sync_byte_default
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH*8-1:0] src_data,
    input  logic [NUM_CH-1:0]   src_valid,
    input  logic [NUM_CH-1:0]   src_last,
    output logic [NUM_CH-1:0]   src_ready,
    output logic [7:0]          usb_upload_data,
    output logic                usb_upload_valid,
    input  logic                usb_upload_ready,
    output logic                err_overlen,
    output logic                busy
);

    localparam int c_idx_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_len_w = $clog2(MAX_LEN + 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [c_idx_w-1:0] r_chan;
    logic [c_idx_w-1:0] w_grant_idx;
    logic [NUM_CH-1:0]  w_grant;
    logic [c_len_w-1:0] r_len;
    logic [7:0]         r_csum;
    logic [7:0]         r_out_data;
    logic               r_out_valid;
    logic               r_err;
    logic               w_load;
    logic               w_emit;
    logic [7:0]         w_emit_byte;
    logic               w_csum_en;
    logic               w_advance;
    logic               w_accept;
    logic               w_trunc;
    logic [NUM_CH-1:0]  w_src_ready;
    logic [7:0]         w_src_byte;
    logic               w_src_valid;
    logic               w_src_last;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (c_idx_w)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (src_valid),
        .advance   (w_advance),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_load = !r_out_valid || usb_upload_ready;

    always_comb begin
        w_src_byte  = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_chan == c_idx_w'(i)) begin
                w_src_byte  = src_data[8*i +: 8];
                w_src_valid = src_valid[i];
                w_src_last  = src_last[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every emitting state advances only when the output register can take a byte.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_byte = '0;
        w_csum_en   = 1'b0;
        w_advance   = 1'b0;
        w_accept    = 1'b0;
        w_trunc     = 1'b0;
        w_src_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_advance   = 1'b1;
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_load) begin
                    w_emit      = 1'b1;
                    w_emit_byte = SYNC_BYTE;
                    w_csum_en   = 1'b1;
                    w_state_nxt = ST_CHID;
                end
            end
            ST_CHID: begin
                if (w_load) begin
                    w_emit      = 1'b1;
                    w_emit_byte = chid_byte(4'(r_chan));
                    w_csum_en   = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    w_src_ready[i] = w_load && (r_chan == c_idx_w'(i));
                end
                if (w_load && w_src_valid) begin
                    w_accept    = 1'b1;
                    w_emit      = 1'b1;
                    w_emit_byte = w_src_byte;
                    w_csum_en   = 1'b1;
                    if (w_src_last) begin
                        w_state_nxt = ST_CSUM;
                    end else if (r_len == c_len_w'(MAX_LEN - 1)) begin
                        w_trunc     = 1'b1;
                        w_state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_load) begin
                    w_emit      = 1'b1;
                    w_emit_byte = r_csum;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
            r_csum      <= '0;
            r_len       <= '0;
            r_chan      <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_emit;
                if (w_emit) begin
                    r_out_data <= w_emit_byte;
                end
            end
            r_err <= w_trunc;
            if (w_advance) begin
                r_chan <= w_grant_idx;
                r_csum <= '0;
                r_len  <= '0;
            end else begin
                if (w_csum_en) begin
                    r_csum <= r_csum ^ w_emit_byte;
                end
                if (w_accept) begin
                    r_len <= r_len + c_len_w'(1);
                end
            end
        end
    end

    assign src_ready        = w_src_ready;
    assign usb_upload_data  = r_out_data;
    assign usb_upload_valid = r_out_valid;
    assign err_overlen      = r_err;
    assign busy             = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_upload_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_upload_arbiter
// Description : Randomized scoreboard bench for upload_arbiter framing/arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upload_arbiter;

    localparam int         NUM_CH  = 4;
    localparam int         MAX_LEN = 4;
    localparam logic [7:0] SYNC    = 8'hAA;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_CH*8-1:0] src_data;
    logic [NUM_CH-1:0]   src_valid;
    logic [NUM_CH-1:0]   src_last;
    logic [NUM_CH-1:0]   src_ready;
    logic [7:0]          usb_upload_data;
    logic                usb_upload_valid;
    logic                usb_upload_ready;
    logic                err_overlen;
    logic                busy;

    upload_arbiter #(
        .NUM_CH    (NUM_CH),
        .MAX_LEN   (MAX_LEN),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .src_last         (src_last),
        .src_ready        (src_ready),
        .usb_upload_data  (usb_upload_data),
        .usb_upload_valid (usb_upload_valid),
        .usb_upload_ready (usb_upload_ready),
        .err_overlen      (err_overlen),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         ch;
        int         pos;
        bit         csum;
    } exp_t;

    typedef struct packed {
        logic       last;
        logic [7:0] b;
    } src_item_t;

    exp_t       exp_q[$];
    src_item_t  src_q[NUM_CH][$];
    logic [7:0] pl_q[$];
    int         total   = 0;
    int         bad     = 0;
    int         exp_err = 0;
    int         err_cnt = 0;
    int         cur_ch  = -1;
    bit         gap_en    = 1'b0;
    bit         rnd_ready = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic void push_exp(input logic [7:0] b, input int ch, input int pos, input bit csum);
        exp_t e;
        e.b = b; e.ch = ch; e.pos = pos; e.csum = csum;
        exp_q.push_back(e);
    endfunction

    // Reference model: the stream in pl_q (last on its final byte) becomes
    // MAX_LEN-sized frames, each SYNC, ID, payload, XOR of all three.
    task automatic model_stream(input int ch);
        int         n;
        int         idx;
        int         k;
        logic [7:0] x;
        src_item_t  s;
        n = pl_q.size();
        for (int i = 0; i < n; i++) begin
            s.b = pl_q[i];
            s.last = (i == n - 1);
            src_q[ch].push_back(s);
        end
        idx = 0;
        while (idx < n) begin
            k = (n - idx > MAX_LEN) ? MAX_LEN : n - idx;
            x = SYNC ^ 8'(ch);
            push_exp(SYNC, ch, 0, 1'b0);
            push_exp(8'(ch), ch, 1, 1'b0);
            for (int j = 0; j < k; j++) begin
                push_exp(pl_q[idx + j], ch, 2 + j, 1'b0);
                x = x ^ pl_q[idx + j];
            end
            push_exp(x, ch, 2 + k, 1'b1);
            if (idx + k < n) exp_err++;
            idx += k;
        end
    endtask

    function automatic bit src_pending();
        for (int c = 0; c < NUM_CH; c++) begin
            if (src_q[c].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) check({name, "_timeout_left"}, exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_err_pulses"}, err_cnt, exp_err);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        cur_ch = -1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Source driver: holds data while valid until accepted, optional idle gaps.
    initial begin : driver
        logic [NUM_CH-1:0] fire;
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        usb_upload_ready = 1'b1;
        forever begin
            @(negedge clk);
            fire = src_valid & src_ready;
            @(posedge clk);
            #1;
            usb_upload_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (rst) begin
                    src_q[c].delete();
                    src_valid[c] = 1'b0;
                    src_last[c]  = 1'b0;
                    src_data[c*8 +: 8] = 8'h00;
                end else if (fire[c] || !src_valid[c]) begin
                    if (fire[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
                    if (src_q[c].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                        src_valid[c] = 1'b1;
                        src_data[c*8 +: 8] = src_q[c][0].b;
                        src_last[c] = src_q[c][0].last;
                    end else begin
                        src_valid[c] = 1'b0;
                        src_last[c]  = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each output transfer.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err_overlen) err_cnt++;
                if (usb_upload_valid && usb_upload_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", usb_upload_data);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("byte_ch%0d_pos%0d", e.ch, e.pos), int'(usb_upload_data), int'(e.b));
                        if (e.pos == 1) cur_ch = e.ch;
                        if (e.csum) cur_ch = -1;
                    end
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (c != cur_ch) check($sformatf("src_ready_idle_ch%0d", c), int'(src_ready[c]), 0);
                end
            end
        end
    end

    initial begin : main
        int ch;
        int len;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_valid", int'(usb_upload_valid), 0);
        check("rst_data", int'(usb_upload_data), 0);
        check("rst_src_ready", int'(src_ready), 0);
        check("rst_err", int'(err_overlen), 0);
        check("rst_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Two-byte frame on channel 1
        @(posedge clk); #2;
        pl_q = {};
        pl_q.push_back(8'h11);
        pl_q.push_back(8'h22);
        model_stream(1);
        wait_done("ch1_basic");

        // Channels 0 and 2 requesting together straight after reset
        pulse_reset();
        @(posedge clk); #2;
        pl_q = {};
        for (int j = 0; j < 3; j++) pl_q.push_back(8'($urandom));
        model_stream(0);
        pl_q = {};
        for (int j = 0; j < 2; j++) pl_q.push_back(8'($urandom));
        model_stream(2);
        wait_done("ch0_ch2");

        // Six bytes on channel 3 split by the length limit
        @(posedge clk); #2;
        pl_q = {};
        for (int j = 0; j < 6; j++) pl_q.push_back(8'(8'h30 + j));
        model_stream(3);
        wait_done("overlen");

        // Ten-byte stream under random back-pressure
        rnd_ready = 1'b1;
        @(posedge clk); #2;
        pl_q = {};
        for (int j = 0; j < 10; j++) pl_q.push_back(8'($urandom));
        model_stream(2);
        wait_done("backpressure");
        rnd_ready = 1'b0;

        // All channels busy with 1-byte frames: strict rotation from channel 0
        pulse_reset();
        @(posedge clk); #2;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pl_q = {};
                pl_q.push_back(8'($urandom));
                model_stream(c);
            end
        end
        wait_done("rotation");

        // Random single-channel streams with source gaps and back-pressure
        gap_en = 1'b1;
        rnd_ready = 1'b1;
        for (int it = 0; it < 12; it++) begin
            ch  = $urandom_range(0, NUM_CH - 1);
            len = $urandom_range(1, 9);
            @(posedge clk); #2;
            pl_q = {};
            for (int j = 0; j < len; j++) pl_q.push_back(8'($urandom));
            model_stream(ch);
            wait_done("random");
        end
        gap_en = 1'b0;
        rnd_ready = 1'b0;

        // Source stalls mid-frame, then reset abandons the frame
        @(posedge clk); #2;
        src_q[0].push_back(src_item_t'{last: 1'b0, b: 8'h31});
        src_q[0].push_back(src_item_t'{last: 1'b0, b: 8'h32});
        push_exp(SYNC, 0, 0, 1'b0);
        push_exp(8'h00, 0, 1, 1'b0);
        push_exp(8'h31, 0, 2, 1'b0);
        push_exp(8'h32, 0, 3, 1'b0);
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(posedge clk);
        check("stall_bytes_left", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        check("stall_busy", int'(busy), 1);
        check("stall_valid", int'(usb_upload_valid), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        cur_ch = -1;
        #1;
        check("midrst_valid", int'(usb_upload_valid), 0);
        check("midrst_data", int'(usb_upload_data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_src_ready", int'(src_ready), 0);
        check("midrst_err", int'(err_overlen), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        pl_q = {};
        pl_q.push_back(8'h5A);
        model_stream(0);
        wait_done("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
